// File: rtl/hilo_divider_if.sv
// Start/done handshake and operand/result bus for the Hi/Lo divider.
interface hilo_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             Sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] Hi_out;
  logic [WIDTH-1:0] Lo_out;

  modport master (
    output start, Sign, A, B,
    input  busy, done, div_by_zero, Hi_out, Lo_out
  );

  modport slave (
    input  start, Sign, A, B,
    output busy, done, div_by_zero, Hi_out, Lo_out
  );
endinterface

// File: rtl/hilo_divider.sv
// Multi-cycle radix-2 restoring divider: Lo = quotient, Hi = remainder (MIPS DIV/DIVU).
module hilo_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  hilo_divider_if.slave  bus
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    accept    = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    a_neg     = bus.Sign & bus.A[WIDTH-1];
    b_neg     = bus.Sign & bus.B[WIDTH-1];
    a_mag     = a_neg ? (~bus.A + WIDTH'(1)) : bus.A;
    b_mag     = b_neg ? (~bus.B + WIDTH'(1)) : bus.B;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {2'b00, b_q};
    trial_ok  = ~trial[WIDTH+1];
    rem_d     = trial_ok ? trial[WIDTH:0] : rem_shift[WIDTH:0];
    quo_d     = {quo_q[WIDTH-2:0], trial_ok};
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      quo_q   <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (accept) begin
            if (bus.B == '0) begin
              lo_q    <= '1;
              hi_q    <= bus.A;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              quo_q   <= a_mag;
              b_q     <= b_mag;
              rem_q   <= '0;
              cnt_q   <= '0;
              q_neg_q <= bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              r_neg_q <= a_neg;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          lo_q    <= q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
          hi_q    <= r_neg_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.Hi_out      = hi_q;
  assign bus.Lo_out      = lo_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Scoreboard bench for hilo_divider: random and directed divides against an arithmetic model.
module tb_hilo_divider;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];

  hilo_divider_if #(.WIDTH(32)) ifc ();

  hilo_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Truncating division from plain 64-bit arithmetic.
  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sbv;
    longint q;
    longint r;
    if (b == 32'h0) begin
      e.lo  = 32'hFFFF_FFFF;
      e.hi  = a;
      e.dbz = 1'b1;
    end else begin
      if (s) begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
      end else begin
        sa  = longint'({32'h0, a});
        sbv = longint'({32'h0, b});
      end
      q     = sa / sbv;
      r     = sa % sbv;
      e.lo  = q[31:0];
      e.hi  = r[31:0];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse pops and compares one expected result.
  always @(negedge clk) begin
    if (rst_n && ifc.done) begin
      check("busy_low_at_done", 32'(ifc.busy), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", ifc.Lo_out, e.lo);
        check("hi", ifc.Hi_out, e.hi);
        check("dbz", 32'(ifc.div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Issue one divide at the current negedge and return at the negedge of its done cycle.
  // inj_at > 0 pulses a 9/3 start at that cycle of the operation, which must be ignored.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int inj_at);
    int busy_cnt;
    int lat;
    bit got;
    busy_cnt = 0;
    lat      = 0;
    got      = 1'b0;
    sb.push_back(model(s, a, b));
    ifc.start = 1'b1;
    ifc.Sign  = s;
    ifc.A     = a;
    ifc.B     = b;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (inj_at == n) begin
        ifc.start = 1'b1;
        ifc.Sign  = 1'b0;
        ifc.A     = 32'd9;
        ifc.B     = 32'd3;
      end else begin
        ifc.start = 1'b0;
      end
      if (ifc.busy) busy_cnt++;
      if (ifc.done) begin
        got = 1'b1;
        lat = n;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), (b == 32'h0) ? 32'd1 : 32'd34);
    check("busy_cycles", 32'(busy_cnt), (b == 32'h0) ? 32'd0 : 32'd33);
  endtask

  initial begin
    int dcount;
    logic [31:0] ra;
    logic [31:0] rb;
    int sel;
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.Sign  = 1'b0;
    ifc.A     = '0;
    ifc.B     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_dbz", 32'(ifc.div_by_zero), 32'd0);
    check("rst_hi", ifc.Hi_out, 32'd0);
    check("rst_lo", ifc.Lo_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7 unsigned, with single done pulse and held results.
    do_op(1'b0, 32'd100, 32'd7, 0);
    check("u100_7_lo", ifc.Lo_out, 32'd14);
    check("u100_7_hi", ifc.Hi_out, 32'd2);
    @(negedge clk);
    check("done_one_cycle", 32'(ifc.done), 32'd0);
    check("hold_lo", ifc.Lo_out, 32'd14);
    check("hold_hi", ifc.Hi_out, 32'd2);

    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    check("s_m7_2_lo", ifc.Lo_out, 32'hFFFF_FFFD);
    check("s_m7_2_hi", ifc.Hi_out, 32'hFFFF_FFFF);
    @(negedge clk);
    do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    check("u_fff9_2_lo", ifc.Lo_out, 32'h7FFF_FFFC);
    check("u_fff9_2_hi", ifc.Hi_out, 32'd1);
    @(negedge clk);
    do_op(1'b0, 32'd5, 32'd0, 0);
    check("dz_lo", ifc.Lo_out, 32'hFFFF_FFFF);
    check("dz_hi", ifc.Hi_out, 32'd5);
    check("dz_flag", 32'(ifc.div_by_zero), 32'd1);
    @(negedge clk);
    check("dz_flag_held", 32'(ifc.div_by_zero), 32'd1);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_lo", ifc.Lo_out, 32'h8000_0000);
    check("ovf_hi", ifc.Hi_out, 32'd0);
    @(negedge clk);

    // Start ignored mid-CALC, then a back-to-back start in the DONE cycle.
    do_op(1'b0, 32'd100, 32'd7, 5);
    check("ign_lo", ifc.Lo_out, 32'd14);
    check("ign_hi", ifc.Hi_out, 32'd2);
    do_op(1'b0, 32'd9, 32'd3, 0);
    check("b2b_lo", ifc.Lo_out, 32'd3);
    check("b2b_hi", ifc.Hi_out, 32'd0);
    @(negedge clk);

    // Randomized operations, mixing gaps and back-to-back issue.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
      if (sel == 0)      rb = 32'h0;
      else if (sel <= 3) rb = 32'($urandom_range(1, 15));
      else if (sel == 4) rb = 32'hFFFF_FFFF;
      else               rb = $urandom;
      do_op(1'($urandom_range(0, 1)), ra, rb, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset during CALC abandons the operation.
    ifc.start = 1'b1;
    ifc.Sign  = 1'b0;
    ifc.A     = 32'd1000;
    ifc.B     = 32'd3;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", 32'(ifc.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(ifc.busy), 32'd0);
    check("arst_done", 32'(ifc.done), 32'd0);
    check("arst_hi", ifc.Hi_out, 32'd0);
    check("arst_lo", ifc.Lo_out, 32'd0);
    check("arst_dbz", 32'(ifc.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) dcount++;
    end
    check("no_done_after_rst", 32'(dcount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_divider.md
# hilo_divider

Multi-cycle 32-bit integer divider that produces MIPS-style Hi/Lo results: Lo = quotient, Hi = remainder. It is the inverse-direction companion to the ALU's combinational multiply, and sits beside the ALU in the execute stage. DIV/DIVU issue here through a start/done handshake. Signed and unsigned division use a radix-2 restoring algorithm, one quotient bit per cycle.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a division; sampled on clk rise
- Sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- A  input  32  dividend; sampled with start
- B  input  32  divisor; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; Hi_out/Lo_out valid from this cycle on
- div_by_zero  output  1  set with done when B was 0; held with the results
- Hi_out  output  32  remainder
- Lo_out  output  32  quotient

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept rule: start is accepted only in IDLE or DONE. start in CALC/FIX is ignored; no queueing.
- On accept with B != 0:
  - latch |A|, |B| (magnitudes when Sign=1, raw otherwise)
  - latch q_neg = Sign & (A[31]^B[31]) and r_neg = Sign & A[31]
  - clear the partial remainder; count = 0; go to CALC
- CALC, one iteration per cycle:
  - shift {rem, quo} left 1
  - trial = rem - |B| (33-bit)
  - if trial >= 0: rem = trial, quo[0] = 1
  - count increments; after the 32nd iteration go to FIX
- FIX:
  - Lo_out = q_neg ? -quo : quo
  - Hi_out = r_neg ? -rem : rem
  - div_by_zero = 0; go to DONE
- On accept with B == 0:
  - go directly to DONE
  - Lo_out = 32'hFFFFFFFF, Hi_out = A, div_by_zero = 1
- DONE: done = 1 for exactly one cycle. Without a new start, go to IDLE. With a start, accept it (back-to-back).
- Hi_out, Lo_out and div_by_zero hold their values until the next operation writes them. They are not cleared on accept.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: no special case. Magnitude math gives Lo = 0x80000000, Hi = 0. No trap or flag.
- Magnitudes are computed in 32-bit unsigned, so |0x80000000| = 0x80000000 is exact.
- Width rules:
  - the partial remainder is 33 bits internally
  - results are truncated to 32 bits
  - signed results satisfy A = Lo*B + Hi, with the sign of Hi equal to the sign of A (truncating division)

## Timing
- Reset (rst_n low, asynchronous, at any time including mid-CALC):
  - state = IDLE
  - busy = 0, done = 0, div_by_zero = 0
  - Hi_out = 0, Lo_out = 0
  - count and internal operand registers = 0
  - the operation is abandoned
- Accepting edge E0, normal divide:
  - CALC iterations on edges E1..E32
  - FIX writes the results at E33
  - done is high in the cycle after E33, i.e. 34 cycles from start assertion to the done-cycle edge E34
- busy is high from the cycle after E0 through the FIX cycle. It is low in IDLE and DONE.
- Divide by zero: results are written at E0, and done is high in the cycle after E0. busy never rises.
- Back-to-back: start high during the DONE cycle is accepted at that edge. done drops and busy rises next cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7, Sign=0:
  - Lo_out = 14, Hi_out = 2, div_by_zero = 0
  - done pulses exactly once, 33 edges after the accepting edge
  - busy is high for 33 cycles
- Signed 0xFFFFFFF9 / 2, Sign=1 (-7/2) -> Lo_out = 0xFFFFFFFD, Hi_out = 0xFFFFFFFF.
- Same operands, Sign=0 -> Lo_out = 0x7FFFFFFC, Hi_out = 1.
- 5 / 0 -> done in the cycle after accept, busy stays 0, Lo_out = 0xFFFFFFFF, Hi_out = 5, div_by_zero = 1.
- Signed 0x80000000 / 0xFFFFFFFF -> Lo_out = 0x80000000, Hi_out = 0.
- Start 100/7, then:
  - pulse start with 9/3 during CALC iteration 5 -> ignored; result still 14/2
  - issue start 9/3 during the DONE cycle -> Lo_out = 3, Hi_out = 0 follow with no idle gap
  - start 1000/3, drive rst_n low at iteration 10 -> busy, done, Hi_out and Lo_out are 0 immediately, without waiting for a clock edge; no done pulse follows
